alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Registered, handshaked, width-parametrised successor to the core combinational ALU. It accepts one operation per transaction on a valid/ready input channel and returns the result plus flags on a valid/ready output channel. Single-cycle ops complete in 1 cycle; a new iterative multiply runs for WIDTH cycles. It sits between the decode/issue stage and writeback, and it decouples the datapath from a stalled writeback.

Parameters:
WIDTH, 24, operand/result width in bits (legal range 2..64).
CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived; never overridden).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request this cycle
op  input  4  opcode, sampled on accept
in0  input  WIDTH  operand 0, sampled on accept
in1  input  WIDTH  operand 1, sampled on accept
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
out  output  WIDTH  result
zf  output  1  zero/equal flag
cf  output  1  carry/borrow/overflow flag
err  output  1  illegal opcode flag

Behaviour:
- Clock/reset decided: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset, including mid-operation: state=IDLE; out, zf, cf and err are 0; out_valid=0; the iteration counter and multiply accumulator are 0. Any in-flight op is discarded.
- FSM states: IDLE, BUSY, DONE.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accepting a non-MUL op: the result registers load and the next state is DONE. Latency is 1 cycle from accept to out_valid.
- Accepting MUL: the operands are latched, the accumulator and counter are cleared, and the next state is BUSY.
- BUSY, one shift-add step per cycle, LSB of multiplier first:
  - After WIDTH steps, state goes to DONE.
  - MUL latency is WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout BUSY.
- DONE: out_valid=1, and out/zf/cf/err hold stable until out_ready.
  - out_ready && !in_valid: go to IDLE.
  - out_ready && accepted: behave as an accept from IDLE in the same cycle (back-to-back, no bubble).
- out_valid=0 in IDLE and BUSY. The out/flag registers keep their last value and are don't-care while out_valid=0.
- Opcodes (all arithmetic modulo 2^WIDTH, unsigned):
  - 0 AND: in0&in1; zf=0, cf=0.
  - 1 OR: in0|in1; zf=0, cf=0.
  - 2 ADD: in0+in1; cf=carry out; zf=0.
  - 3 SUB: |in0-in1| (larger minus smaller); cf=(in1>in0); zf=0.
  - 4 INC: in1+1; cf=(in1 all ones), result wraps to 0; zf=0.
  - 5 DEC: in1-1; cf=(in1==0), result wraps to all ones; zf=0.
  - 6 COMP: out=0; zf=(in0==in1); cf=0.
  - 7 PASS: out=in0; zf=0, cf=0.
  - 8 MUL: out = low WIDTH bits of in0*in1; cf=1 iff the high WIDTH bits are nonzero; zf=0.
  - 9..15 illegal: out=0, zf=0, cf=0, err=1, 1-cycle latency.
  - err=0 for all legal ops.
- Inputs are ignored when not accepted. op/in0/in1 changes during BUSY or DONE have no effect.
- in_valid is not required to stay high without acceptance. The block never drops out_valid before out_ready.

Test Plan:
- Reset with no traffic → out_valid=0, in_ready=1, out/zf/cf/err=0. Assert rst_n low mid-BUSY of a MUL → immediately IDLE, out_valid=0. After release, the next ADD completes normally.
- ADD in0=0xFFFFFF, in1=0x000001, out_ready=1 → out_valid 1 cycle after accept, out=0x000000, cf=1. SUB in0=5, in1=9 → out=4, cf=1.
- INC in1=0xFFFFFF → out=0, cf=1. DEC in1=0 → out=0xFFFFFF, cf=1. COMP in0=in1=0x123456 → out=0, zf=1. COMP 0x123456 vs 0x123457 → zf=0.
- MUL in0=0x001000, in1=0x000100 → in_ready=0 for 24 cycles, out_valid at accept+25, out=0x100000, cf=0. MUL 0x800000×2 → out=0, cf=1.
- Backpressure: out_ready=0 for 10 cycles after an OR result (0xF0F0F0|0x0F0F0F) → out=0xFFFFFF held, out_valid stays 1, in_ready=0. Then out_ready=1 with in_valid=1 (PASS in0=0xABCDEF) → accepted the same cycle, next cycle out=0xABCDEF.
- Illegal op=12 → err=1, out=0, 1-cycle latency. Back-to-back stream of 8 ADDs with out_ready=1 → one result per cycle after the first, no bubbles.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response channel bundle between issue and writeback
interface alu_seq_if #(parameter int WIDTH = 24);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zf;
    logic             cf;
    logic             err;
    modport master (
        output in_valid, op, in0, in1, out_ready,
        input  in_ready, out_valid, out, zf, cf, err
    );
    modport slave (
        input  in_valid, op, in0, in1, out_ready,
        output in_ready, out_valid, out, zf, cf, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU with iterative shift-add multiply
module alu_seq #(
    parameter  int WIDTH = 24,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state, state_nx;
    logic               accept, is_mul, last;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, mcand, sum;
    logic [WIDTH-1:0]   mplier, res, diff;
    logic [WIDTH:0]     add_s;
    logic               rz, rc, re;
    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = (bus.op == 4'd8);
    assign last   = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
    assign sum    = acc + (mplier[0] ? mcand : '0);
    assign add_s  = {1'b0, bus.in0} + {1'b0, bus.in1};
    assign diff   = (bus.in1 > bus.in0) ? bus.in1 - bus.in0 : bus.in0 - bus.in1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        if (accept)                           state_nx = is_mul ? BUSY : DONE;
        else if (last)                        state_nx = DONE;
        else if (state == DONE && bus.out_ready) state_nx = IDLE;
    end
    always_comb begin
        res = '0;
        rz  = 1'b0;
        rc  = 1'b0;
        re  = 1'b0;
        case (bus.op)
            4'd0: res = bus.in0 & bus.in1;
            4'd1: res = bus.in0 | bus.in1;
            4'd2: {rc, res} = add_s;
            4'd3: begin res = diff; rc = bus.in1 > bus.in0; end
            4'd4: begin res = bus.in1 + WIDTH'(1); rc = &bus.in1; end
            4'd5: begin res = bus.in1 - WIDTH'(1); rc = ~|bus.in1; end
            4'd6: rz = (bus.in0 == bus.in1);
            4'd7: res = bus.in0;
            4'd8: res = '0;
            default: re = 1'b1;
        endcase
    end
    // multiplicand shifts left while multiplier shifts right, one partial product per cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out <= '0;
            bus.zf  <= 1'b0;
            bus.cf  <= 1'b0;
            bus.err <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {WIDTH'(0), bus.in0};
                mplier <= bus.in1;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                bus.out <= res;
                bus.zf  <= rz;
                bus.cf  <= rc;
                bus.err <= re;
            end
        end else if (state == BUSY) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                bus.out <= sum[WIDTH-1:0];
                bus.zf  <= 1'b0;
                bus.cf  <= |sum[2*WIDTH-1:WIDTH];
                bus.err <= 1'b0;
            end
        end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W = 24;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic c, output logic e);
        logic [127:0] x, y, m, t;
        x = 128'(a);
        y = 128'(b);
        m = 128'd1 << W;
        t = '0;
        z = 1'b0;
        c = 1'b0;
        e = 1'b0;
        case (o)
            4'd0: t = x & y;
            4'd1: t = x | y;
            4'd2: begin t = x + y; c = t >= m; end
            4'd3: begin t = (y > x) ? y - x : x - y; c = y > x; end
            4'd4: begin t = y + 1; c = t >= m; end
            4'd5: begin t = y + m - 1; c = (y == 0); end
            4'd6: z = (x == y);
            4'd7: t = x;
            4'd8: begin t = x * y; c = t >= m; end
            default: e = 1'b1;
        endcase
        r = W'(t % m);
    endtask
    task automatic check_result(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic z, c, e;
        model(o, a, b, r, z, c, e);
        check({tag, ".out"}, 64'(bus.out), 64'(r));
        check({tag, ".flags"}, 64'({bus.zf, bus.cf, bus.err}), 64'({z, c, e}));
    endtask
    // one transaction with out_ready high; checks latency, busy stall and result
    task automatic txn(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n, lo;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = o;
        bus.in0       = a;
        bus.in1       = b;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({tag, ".accept_timeout"}, 64'(n), 64'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op  = 4'($urandom);
        bus.in0 = W'($urandom);
        bus.in1 = W'($urandom);
        n  = 1;
        lo = 0;
        while (!bus.out_valid && n < 200) begin
            if (!bus.in_ready) lo++;
            @(negedge clk);
            bus.in0 = W'($urandom);
            n++;
        end
        check({tag, ".latency"}, 64'(n), (o == 4'd8) ? 64'(W + 1) : 64'(1));
        if (o == 4'd8) check({tag, ".busy_stall"}, 64'(lo), 64'(W));
        check_result(tag, o, a, b);
    endtask
    function automatic logic [W-1:0] pick();
        case ($urandom_range(3))
            0: return '0;
            1: return ONES;
            default: return W'($urandom);
        endcase
    endfunction
    initial begin
        logic [W-1:0] q_a[$], q_b[$];
        logic [W-1:0] r;
        logic z, c, e;
        int bad;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op  = '0;
        bus.in0 = '0;
        bus.in1 = '0;
        #12;
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.in_ready", 64'(bus.in_ready), 64'(1));
        check("rst.out", 64'(bus.out), 64'(0));
        check("rst.flags", 64'({bus.zf, bus.cf, bus.err}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // abort a multiply midway through with reset
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op  = 4'd8;
        bus.in0 = 24'h001000;
        bus.in1 = 24'h000100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midbusy.in_ready_before", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("midbusy.out_valid", 64'(bus.out_valid), 64'(0));
        check("midbusy.in_ready", 64'(bus.in_ready), 64'(1));
        check("midbusy.out", 64'(bus.out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        txn("add_after_rst", 4'd2, 24'h000123, 24'h000456);
        txn("add_carry", 4'd2, 24'hFFFFFF, 24'h000001);
        txn("sub_borrow", 4'd3, 24'd5, 24'd9);
        txn("sub_plain", 4'd3, 24'd9, 24'd5);
        txn("inc_wrap", 4'd4, 24'h0, 24'hFFFFFF);
        txn("dec_wrap", 4'd5, 24'h0, 24'h0);
        txn("comp_eq", 4'd6, 24'h123456, 24'h123456);
        txn("comp_ne", 4'd6, 24'h123456, 24'h123457);
        txn("and", 4'd0, 24'hF0F0F0, 24'h3C3C3C);
        txn("mul", 4'd8, 24'h001000, 24'h000100);
        txn("mul_ovf", 4'd8, 24'h800000, 24'h000002);
        txn("mul_full", 4'd8, ONES, ONES);
        txn("illegal12", 4'd12, 24'h111111, 24'h222222);
        txn("illegal15", 4'd15, 24'h0, 24'h0);
        // hold the OR result under backpressure, then chain a PASS in the release cycle
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op  = 4'd1;
        bus.in0 = 24'hF0F0F0;
        bus.in1 = 24'h0F0F0F;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bad = 0;
        repeat (10) begin
            if (!bus.out_valid || bus.in_ready || bus.out !== 24'hFFFFFF) bad++;
            bus.op  = 4'($urandom);
            bus.in0 = W'($urandom);
            @(negedge clk);
        end
        check("bp.hold_bad_cycles", 64'(bad), 64'(0));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op  = 4'd7;
        bus.in0 = 24'hABCDEF;
        #1;
        check("bp.in_ready_release", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp.pass_valid", 64'(bus.out_valid), 64'(1));
        check("bp.pass_out", 64'(bus.out), 64'hABCDEF);
        // eight ADDs streamed back to back
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                model(4'd2, q_a[0], q_b[0], r, z, c, e);
                check("stream.valid", 64'(bus.out_valid), 64'(1));
                check("stream.out", 64'({c, bus.out}), 64'({bus.cf, r}));
                void'(q_a.pop_front());
                void'(q_b.pop_front());
            end
            if (i < 8) begin
                check("stream.in_ready", 64'(bus.in_ready), 64'(1));
                bus.in_valid = 1'b1;
                bus.op  = 4'd2;
                bus.in0 = pick();
                bus.in1 = pick();
                q_a.push_back(bus.in0);
                q_b.push_back(bus.in1);
            end else bus.in_valid = 1'b0;
        end
        for (int i = 0; i < 120; i++)
            txn("rand", ($urandom_range(3) == 0) ? 4'd8 : 4'($urandom_range(15)), pick(), pick());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
